// File: rtl/rr_mux_arb_if.sv
// Handshake bundle between N producer channels, the arbitrating mux and one consumer.
// The slave modport is the mux's view; master is the view of the surrounding logic.
interface rr_mux_arb_if #(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int SELW = $clog2(N)
);
  logic            mode;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_sel;
  logic            out_ready;

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_mux_arb.sv
// N-channel registered mux with round-robin / fixed-priority arbitration.
// Picks one requesting channel per free output slot and registers its word and index.
module rr_mux_arb #(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  rr_mux_arb_if.slave  bus
);

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_sel_q,   out_sel_d;
  logic [SELW-1:0] ptr_q,       ptr_d;

  logic            load_en;
  logic            grant_found;
  logic [SELW-1:0] grant_idx;

  assign load_en = !out_valid_q || bus.out_ready;

  // NOTE: every variable written in a combinational block gets a default first, otherwise
  // paths that skip an assignment make synthesis infer a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    if (bus.mode) begin
      for (int i = 0; i < N; i++) begin
        if (!grant_found && bus.in_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = SELW'(i);
        end
      end
    end else begin
      // Search starts at ptr and wraps past N-1 back to channel 0.
      for (int k = 0; k < N; k++) begin
        if (!grant_found && bus.in_valid[(int'(ptr_q) + k) % N]) begin
          grant_found = 1'b1;
          grant_idx   = SELW'((int'(ptr_q) + k) % N);
        end
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (!rst && load_en && grant_found) begin
      bus.in_ready = N'(1) << grant_idx;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (grant_found) begin
        out_valid_d = 1'b1;
        out_data_d  = bus.in_data[int'(grant_idx)*W +: W];
        out_sel_d   = grant_idx;
        if (!bus.mode) begin
          ptr_d = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + 1'b1;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: reset, round-robin sweep, single requester,
// wrap-around, backpressure, fixed priority, idle drain and reset mid-operation.
module tb_rr_mux_arb;
  localparam int N = 8;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_mux_arb_if #(.N(N), .W(W)) bus ();

  rr_mux_arb #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [W-1:0] val);
    bus.in_data[ch*W +: W] = val;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] d, input int s);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, "_data"},  32'(bus.out_data),  32'(d));
    check({tag, "_sel"},   32'(bus.out_sel),   32'(s));
  endtask

  initial begin
    rst           = 1'b1;
    bus.mode      = 1'b0;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, 8'h10 + 8'(i));

    // Reset held two cycles with every channel requesting.
    tick();
    tick();
    expect_out("reset", 1'b0, 8'h00, 0);
    check("reset_in_ready", 32'(bus.in_ready), 32'h00);

    // Round-robin sweep 0..7,0 after release; first grant is channel 0.
    rst = 1'b0;
    for (int i = 0; i <= N; i++) begin
      #1;
      check("rr_in_ready", 32'(bus.in_ready), 32'(8'h01 << (i % N)));
      tick();
      expect_out("rr", 1'b1, 8'h10 + 8'(i % N), i % N);
    end
    // ptr = 1

    // Single requester on channel 2.
    bus.in_valid = 8'b0000_0100;
    set_data(2, 8'hA5);
    #1;
    check("single_in_ready", 32'(bus.in_ready), 32'h04);
    tick();
    expect_out("single", 1'b1, 8'hA5, 2);
    // ptr = 3

    // Wrap-around: ptr=3 with channels 0,1 requesting grants 0 then 1.
    bus.in_valid = 8'b0000_0011;
    #1;
    check("wrap_in_ready", 32'(bus.in_ready), 32'h01);
    tick();
    expect_out("wrap0", 1'b1, 8'h10, 0);
    tick();
    expect_out("wrap1", 1'b1, 8'h11, 1);
    // ptr = 2

    // Backpressure: three stalled cycles hold the word and block all grants.
    bus.out_ready = 1'b0;
    bus.in_valid  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", 32'(bus.in_ready), 32'h00);
      tick();
      expect_out("stall", 1'b1, 8'h11, 1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("drain_in_ready", 32'(bus.in_ready), 32'h04);
    tick();
    expect_out("drain", 1'b1, 8'hA5, 2);
    // ptr = 3

    // Fixed priority: lowest requesting index wins, ptr untouched.
    bus.mode     = 1'b1;
    bus.in_valid = 8'b1010_0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("fp2", 1'b1, 8'hA5, 2);
    end
    bus.in_valid = 8'b1010_0000;
    #1;
    check("fp5_in_ready", 32'(bus.in_ready), 32'h20);
    tick();
    expect_out("fp5", 1'b1, 8'h15, 5);

    // Back to round-robin; ptr kept 3, so channel 5 alone moves it to 6.
    bus.mode     = 1'b0;
    bus.in_valid = 8'b0010_0000;
    tick();
    expect_out("rr5", 1'b1, 8'h15, 5);
    bus.in_valid = 8'b0010_0001;
    tick();
    expect_out("ptr6_g0", 1'b1, 8'h10, 0);
    tick();
    expect_out("ptr1_g5", 1'b1, 8'h15, 5);
    // ptr = 6

    // Nothing requesting: word drains, data and sel hold.
    bus.in_valid = 8'h00;
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'h00);
    tick();
    expect_out("idle", 1'b0, 8'h15, 5);

    // Channel 3 moves ptr to 4, then stall and reset mid-operation.
    bus.in_valid = 8'b0000_1000;
    tick();
    expect_out("ch3", 1'b1, 8'h13, 3);
    bus.out_ready = 1'b0;
    bus.in_valid  = 8'hFF;
    tick();
    expect_out("pre_rst", 1'b1, 8'h13, 3);
    rst = 1'b1;
    tick();
    expect_out("mid_rst", 1'b0, 8'h00, 0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'h00);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'h01);
    tick();
    expect_out("post_rst", 1'b1, 8'h10, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_mux_arb.md
# rr_mux_arb

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking and built-in arbitration. It succeeds the combinational 8:1 select mux: instead of an external select, the block picks among requesting input channels by round-robin or fixed priority and registers the chosen word with its channel index. It sits between several producer channels and a single shared consumer (bus, serializer, FIFO).

## Interface
- `N`, 8: number of input channels (≥2).
- `W`, 8: data width per channel.
- `SELW`, `$clog2(N)`: width of channel index. Derived; do not override.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `in_valid`  in  N  per-channel request; bit i belongs to channel i.
- `in_data`  in  N*W  packed channel data; channel i at bits [i*W +: W].
- `in_ready`  out  N  one-hot (or zero) grant; combinational.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  W  registered selected word.
- `out_sel`  out  SELW  registered index of the channel that supplied `out_data`.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`.

## Operation
- Internal state: output register (`out_valid`, `out_data`, `out_sel`) and round-robin pointer `ptr` (SELW bits).
- `load_en = !out_valid || out_ready`. Arbitration happens only when `load_en=1` and `|in_valid`.
- Round-robin (`mode=0`): grant the first valid channel found searching `ptr, ptr+1, …, N-1, 0, …, ptr-1`. After a grant to g, `ptr <= (g==N-1) ? 0 : g+1`.
- Fixed priority (`mode=1`): grant the lowest-index valid channel. `ptr` is not updated.
- `in_ready[g]=1` only for the granted channel in that cycle; all other bits 0. A transfer on channel g happens when `in_valid[g] && in_ready[g]`.
- On a transfer: `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`.
- If `load_en=1` and no input is valid: `out_valid <= 0` if the current word is consumed; `out_data` and `out_sel` hold their last values.
- Stall (`out_valid=1`, `out_ready=0`): `in_ready=0`, and `out_data`, `out_sel`, `ptr` hold.
- `mode` is sampled combinationally each arbitration cycle. A change applies to the next grant, and `ptr` keeps its value across mode changes.
- Producers must not make `in_valid` depend on `in_ready`. `in_ready` may depend combinationally on `in_valid`, `out_valid`, `out_ready`, `mode`, and `ptr`.

## Timing
- Reset (`rst=1` at edge): `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`. While `rst=1`, `in_ready=0`.
- Reset has priority over any simultaneous transfer. A word pending mid-operation is discarded.
- Latency: input transfer at edge k produces `out_valid=1` with that word after edge k (one cycle).
- Throughput: one word per cycle when `out_ready` is held 1. Output drain and new load occur at the same edge.
- Wrap-around: grant to N-1 sets `ptr=0`. With `ptr=3` and `in_valid=8'b00000011`, the grant goes to channel 0.
- A single requester is granted every cycle regardless of `ptr`. No idle bubbles are inserted.
- Fairness: in round-robin with all N valid, each channel is granted exactly once per N consecutive grants.

## Test plan
- Reset: hold `rst=1` 2 cycles with `in_valid=8'hFF` → `out_valid=0`, `out_data=0`, `out_sel=0`, `in_ready=0`. After release, first grant is channel 0.
- Single channel: `in_valid=8'b00000100`, ch2 data `8'hA5`, `out_ready=1` → same cycle `in_ready=8'b00000100`. Next cycle `out_valid=1`, `out_data=8'hA5`, `out_sel=2`.
- Round-robin sweep: `mode=0`, `in_valid=8'hFF`, ch i data `8'h10+i`, `out_ready=1` → `out_sel` sequence 0,1,…,7,0 on consecutive cycles with data `8'h10`…`8'h17`, `8'h10`.
- Backpressure: with `out_valid=1`, hold `out_ready=0` for 3 cycles → `out_data`/`out_sel` stable and `in_ready=8'h00`. When `out_ready=1`, the word drains and the next grant loads at the same edge.
- Fixed priority and wrap: `mode=1`, `in_valid=8'b10100100` → `out_sel=2` every cycle. Clear bit 2 → `out_sel=5`. Then `mode=0` with `ptr=6`, `in_valid=8'b00100001` → grant 0, then 5.
- Reset mid-operation: assert `rst` while `out_valid=1`, `out_ready=0`, `ptr=4` → next cycle `out_valid=0`, `ptr=0`. Release with `in_valid=8'hFF` → first `out_sel=0`.
